ad_jesd204_tx_framer: RTL and testbench

Transmit-side transport framer for a 2-converter, 4-lane JESD204B DAC link. Parameters are L=4, M=2, F=1, S=1 and N'=16. It accepts per-channel DMA sample words, buffers them in a small FIFO, and maps them into the 128-bit octet stream consumed by the JESD204 transmit link layer. It sits between the DAC DMA/unpacker and the link layer, in the same clock domain (tx_clk = line-rate/40). It also detects and reports underflow.

---
 rtl/ad_jesd204_tx_pkg.sv | 19 +
 rtl/ad_jesd204_tx_fifo.sv | 68 ++++++
 rtl/ad_jesd204_tx_framer.sv | 137 +++++++++++++
 tb/tb_ad_jesd204_tx_framer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_jesd204_tx_pkg.sv
// Shared constants and state encoding for the JESD204B (L=4, M=2, F=1, S=1) transmit framer.
package ad_jesd204_tx_pkg;

    localparam int LANE_BITS    = 32;
    localparam int OCTET_BITS   = 8;
    localparam int NUM_LANES    = 4;
    localparam int NUM_FRAMES   = 4;
    localparam int NUM_CHANNELS = 2;
    localparam int SAMPLE_BITS  = 16;
    localparam int DATA_W       = NUM_LANES * LANE_BITS;
    localparam int UF_CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/ad_jesd204_tx_fifo.sv
// Synchronous FIFO with flush. The head word is presented combinationally on rdata.
module ad_jesd204_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

endmodule

// File: rtl/ad_jesd204_tx_framer.sv
// Transport framer: buffers raw DMA sample words and maps them onto 4 lanes on the pop path,
// with IDLE/FILL/RUN streaming control and sticky underflow reporting.
module ad_jesd204_tx_framer
    import ad_jesd204_tx_pkg::*;
#(
    parameter int CHANNEL_WIDTH = 14,
    parameter int DATA_FORMAT   = 0,
    parameter int FIFO_DEPTH    = 4,
    parameter int FILL_LEVEL    = 2
) (
    input  logic          tx_clk,
    input  logic          tx_rst,
    input  logic          enable,
    input  logic          dac_enable_0,
    input  logic          dac_enable_1,
    input  logic          dac_valid,
    output logic          dac_ready,
    input  logic [63:0]   dac_data_0,
    input  logic [63:0]   dac_data_1,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [127:0]  tx_data,
    output logic          status_underflow,
    input  logic          status_underflow_clr,
    output logic [15:0]   underflow_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]       FILL_CNT  = CNT_W'(FILL_LEVEL);
    localparam logic [SAMPLE_BITS-1:0] KEEP_MASK = 16'hFFFF << (SAMPLE_BITS - CHANNEL_WIDTH);
    localparam logic [SAMPLE_BITS-1:0] FMT_MASK  = (DATA_FORMAT != 0) ? 16'h8000 : 16'h0000;

    state_e                state_q, state_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0]     tx_data_q, tx_data_d;
    logic                  uf_flag_q, uf_flag_d;
    logic [UF_CNT_W-1:0]   uf_cnt_q, uf_cnt_d;

    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full, fifo_empty, fifo_flush;
    logic [DATA_W-1:0]     fifo_head, mapped;
    logic                  push, pop, run_beat, underflow;
    logic [NUM_CHANNELS-1:0] ch_en;

    assign ch_en      = {dac_enable_1, dac_enable_0};
    assign dac_ready  = (state_q != ST_IDLE) && !fifo_full;
    assign push       = dac_valid && dac_ready;
    assign run_beat   = enable && (state_q == ST_RUN) && tx_ready;
    assign pop        = run_beat && !fifo_empty;
    assign underflow  = run_beat && fifo_empty;
    assign fifo_flush = !enable || (state_q == ST_IDLE);

    ad_jesd204_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (tx_clk),
        .rst   (tx_rst),
        .flush (fifo_flush),
        .push  (push),
        .pop   (pop),
        .wdata ({dac_data_1, dac_data_0}),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Channel c, frame f: MSB octet to lane 2c, LSB octet to lane 2c+1, both at octet slot f.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        for (genvar f = 0; f < NUM_FRAMES; f++) begin : g_fr
            logic [SAMPLE_BITS-1:0] smp;
            assign smp = ch_en[c]
                ? ((fifo_head[c*64 + f*SAMPLE_BITS +: SAMPLE_BITS] & KEEP_MASK) ^ FMT_MASK)
                : '0;
            assign mapped[(2*c)*LANE_BITS   + f*OCTET_BITS +: OCTET_BITS] = smp[15:8];
            assign mapped[(2*c+1)*LANE_BITS + f*OCTET_BITS +: OCTET_BITS] = smp[7:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        uf_flag_d = uf_flag_q;
        uf_cnt_d  = uf_cnt_q;

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_FILL;
                ST_FILL: if (fifo_count >= FILL_CNT) state_d = ST_RUN;
                ST_RUN:  if (underflow) state_d = ST_FILL;
                default: state_d = ST_IDLE;
            endcase
        end

        // Outside RUN the stream carries zeros; in RUN data only moves on tx_ready.
        if (!enable || state_q != ST_RUN) tx_data_d = '0;
        else if (pop)                     tx_data_d = mapped;
        else if (underflow)               tx_data_d = '0;

        tx_valid_d = (state_d != ST_IDLE);

        if (status_underflow_clr) begin
            uf_flag_d = 1'b0;
            uf_cnt_d  = '0;
        end
        if (underflow) begin
            uf_flag_d = 1'b1;
            if (status_underflow_clr) uf_cnt_d = UF_CNT_W'(1);
            else if (uf_cnt_q != '1)  uf_cnt_d = uf_cnt_q + UF_CNT_W'(1);
        end
    end

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            uf_flag_q  <= 1'b0;
            uf_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            uf_flag_q  <= uf_flag_d;
            uf_cnt_q   <= uf_cnt_d;
        end
    end

    assign tx_valid         = tx_valid_q;
    assign tx_data          = tx_data_q;
    assign status_underflow = uf_flag_q;
    assign underflow_count  = uf_cnt_q;

endmodule

// File: tb/tb_ad_jesd204_tx_framer.sv
// Scoreboard bench: a queue-based reference model predicts every cycle's outputs for a
// two's-complement and an offset-binary instance driven by the same stimulus.
module tb_ad_jesd204_tx_framer;

    localparam int CHW   = 14;
    localparam int DEPTH = 4;
    localparam int FILL  = 2;

    logic         clk = 1'b0;
    logic         rst, enable, en0, en1, dac_valid, tx_ready, clr;
    logic [63:0]  d0, d1;

    logic         dac_ready0, dac_ready1, tx_valid0, tx_valid1, uf0, uf1;
    logic [127:0] tx_data0, tx_data1;
    logic [15:0]  ufc0, ufc1;

    always #5 clk = ~clk;

    ad_jesd204_tx_framer #(.CHANNEL_WIDTH(CHW), .DATA_FORMAT(0), .FIFO_DEPTH(DEPTH), .FILL_LEVEL(FILL)) dut0 (
        .tx_clk(clk), .tx_rst(rst), .enable(enable), .dac_enable_0(en0), .dac_enable_1(en1),
        .dac_valid(dac_valid), .dac_ready(dac_ready0), .dac_data_0(d0), .dac_data_1(d1),
        .tx_valid(tx_valid0), .tx_ready(tx_ready), .tx_data(tx_data0),
        .status_underflow(uf0), .status_underflow_clr(clr), .underflow_count(ufc0));

    ad_jesd204_tx_framer #(.CHANNEL_WIDTH(CHW), .DATA_FORMAT(1), .FIFO_DEPTH(DEPTH), .FILL_LEVEL(FILL)) dut1 (
        .tx_clk(clk), .tx_rst(rst), .enable(enable), .dac_enable_0(en0), .dac_enable_1(en1),
        .dac_valid(dac_valid), .dac_ready(dac_ready1), .dac_data_0(d0), .dac_data_1(d1),
        .tx_valid(tx_valid1), .tx_ready(tx_ready), .tx_data(tx_data1),
        .status_underflow(uf1), .status_underflow_clr(clr), .underflow_count(ufc1));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sample value after truncation to CHW bits, optional offset-binary, channel enable.
    function automatic logic [127:0] map_word(input logic [127:0] raw, input logic [1:0] en, input bit ob);
        logic [127:0] o;
        logic [15:0]  s;
        int           scale;
        o     = '0;
        scale = 1 << (16 - CHW);
        for (int c = 0; c < 2; c++) begin
            for (int f = 0; f < 4; f++) begin
                s = raw[c*64 + f*16 +: 16];
                s = 16'((int'(s) / scale) * scale);
                if (ob) s = s ^ 16'h8000;
                if (!en[c]) s = '0;
                o[(2*c)*32   + f*8 +: 8] = s[15:8];
                o[(2*c+1)*32 + f*8 +: 8] = s[7:0];
            end
        end
        return o;
    endfunction

    typedef struct {
        logic         valid;
        logic         ready;
        logic [127:0] d0;
        logic [127:0] d1;
        logic         flag;
        logic [15:0]  cnt;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] mq[$];
    int           m_mode;      // 0 idle, 1 fill, 2 run
    logic [127:0] m_raw;
    logic [1:0]   m_en;
    bit           m_zero;
    logic         m_flag;
    logic [15:0]  m_cnt;

    // Reference model: advances on each edge from the inputs the DUT sees at that edge.
    always @(posedge clk) begin
        exp_t e;
        int   sz;
        bit   rdy, beat, uf;
        if (rst) begin
            mq.delete();
            m_mode = 0; m_zero = 1; m_flag = 0; m_cnt = 0;
        end else begin
            sz   = mq.size();
            rdy  = (m_mode != 0) && (sz < DEPTH);
            beat = enable && (m_mode == 2) && tx_ready;
            uf   = beat && (sz == 0);
            if (!enable || m_mode != 2) m_zero = 1;
            else if (beat && !uf) begin
                m_raw  = mq.pop_front();
                m_en   = {en1, en0};
                m_zero = 0;
            end else if (uf) m_zero = 1;
            if (clr) begin m_flag = 0; m_cnt = 0; end
            if (uf) begin
                m_flag = 1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            if (dac_valid && rdy) mq.push_back({d1, d0});
            if (!enable) begin
                m_mode = 0;
                mq.delete();
            end else if (m_mode == 0) m_mode = 1;
            else if (m_mode == 1 && sz >= FILL) m_mode = 2;
            else if (uf) m_mode = 1;
        end
        e.valid = (m_mode != 0);
        e.ready = (m_mode != 0) && (mq.size() < DEPTH);
        e.d0    = m_zero ? 128'h0 : map_word(m_raw, m_en, 0);
        e.d1    = m_zero ? 128'h0 : map_word(m_raw, m_en, 1);
        e.flag  = m_flag;
        e.cnt   = m_cnt;
        exp_q.push_back(e);
    end

    // Monitor: compares outputs against the oldest prediction, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("tx_valid0", 128'(tx_valid0), 128'(e.valid));
            chk("tx_valid1", 128'(tx_valid1), 128'(e.valid));
            chk("dac_ready0", 128'(dac_ready0), 128'(e.ready));
            chk("dac_ready1", 128'(dac_ready1), 128'(e.ready));
            chk("tx_data_tc", tx_data0, e.d0);
            chk("tx_data_ob", tx_data1, e.d1);
            chk("underflow_flag", 128'(uf0), 128'(e.flag));
            chk("underflow_count", 128'(ufc0), 128'(e.cnt));
            chk("underflow_count_ob", 128'(ufc1), 128'(e.cnt));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rnd_data();
        d0 = {$urandom, $urandom};
        d1 = {$urandom, $urandom};
    endtask

    task automatic wait_nonzero(input string name);
        int i;
        for (i = 0; i < 30 && tx_data0 == '0; i++) step(1);
        chk({name, "_timeout"}, 128'(tx_data0 != '0), 128'(1));
    endtask

    task automatic wait_run_q(input int n, input string name);
        int i;
        for (i = 0; i < 30 && !(m_mode == 2 && mq.size() == n); i++) step(1);
        chk({name, "_timeout"}, 128'(m_mode == 2 && mq.size() == n), 128'(1));
    endtask

    initial begin
        rst = 1; enable = 0; en0 = 0; en1 = 0; dac_valid = 0; tx_ready = 0; clr = 0;
        d0 = '0; d1 = '0;
        step(3);
        rst = 0;

        // Mapping and fill: first push at cycle 3, two words to reach the fill level.
        enable = 1; en0 = 1; en1 = 1; tx_ready = 1;
        step(3);
        d0 = {48'h0123_4567_89AB, 16'h1237};
        d1 = {16'hABCD, 48'h1111_2222_3333};
        dac_valid = 1;
        step(1);
        rnd_data();
        step(1);
        dac_valid = 0;
        wait_nonzero("map");
        chk("lane0_oct0", 128'(tx_data0[7:0]),    128'(8'h12));
        chk("lane1_oct0", 128'(tx_data0[39:32]),  128'(8'h34));
        chk("lane2_oct3", 128'(tx_data0[95:88]),  128'(8'hAB));
        chk("lane3_oct3", 128'(tx_data0[127:120]), 128'(8'hCC));
        chk("ob_lane0_oct0", 128'(tx_data1[7:0]),   128'(8'h92));
        chk("ob_lane1_oct0", 128'(tx_data1[39:32]), 128'(8'h34));

        // Underflow once the two words drain.
        begin
            int i;
            for (i = 0; i < 20 && !m_flag; i++) step(1);
        end
        chk("uf_flag_set", 128'(uf0), 128'(1));
        chk("uf_count_one", 128'(ufc0), 128'(16'd1));
        chk("uf_zero_beat", tx_data0, 128'h0);

        // Second underflow coincident with clear: underflow wins.
        dac_valid = 1; rnd_data(); step(1); rnd_data(); step(1);
        dac_valid = 0;
        wait_run_q(0, "uf2");
        clr = 1;
        step(1);
        clr = 0;
        chk("clr_uf_flag", 128'(uf0), 128'(1));
        chk("clr_uf_count", 128'(ufc0), 128'(16'd1));

        // Channel 1 disabled: lanes 2-3 zero.
        en1 = 0;
        dac_valid = 1;
        for (int k = 0; k < 4; k++) begin rnd_data(); d0[15:14] = 2'b01; step(1); end
        dac_valid = 0;
        wait_nonzero("dis");
        chk("dis_lanes23_tc", tx_data0[127:64], 128'h0);
        chk("dis_lanes23_ob", tx_data1[127:64], 128'h0);
        step(8);
        en1 = 1;

        // Backpressure: stall the link while the DMA keeps pushing.
        dac_valid = 1;
        for (int k = 0; k < 3; k++) begin rnd_data(); step(1); end
        tx_ready = 0;
        for (int k = 0; k < 6; k++) begin rnd_data(); step(1); end
        chk("bp_dac_ready_low", 128'(dac_ready0), 128'(0));
        dac_valid = 0; tx_ready = 1;
        step(10);

        // Reset mid-RUN with three entries queued, then fresh traffic.
        tx_ready = 0; dac_valid = 1;
        rnd_data();
        wait_run_q(3, "rst_fill");
        dac_valid = 0; rst = 1;
        step(1);
        rst = 0;
        chk("rst_tx_valid", 128'(tx_valid0), 128'(0));
        chk("rst_dac_ready", 128'(dac_ready0), 128'(0));
        tx_ready = 1; dac_valid = 1;
        for (int k = 0; k < 4; k++) begin rnd_data(); step(1); end
        dac_valid = 0;
        step(8);

        // Disable mid-RUN with three entries queued.
        tx_ready = 0; dac_valid = 1;
        rnd_data();
        wait_run_q(3, "dis_fill");
        dac_valid = 0; enable = 0;
        step(1);
        chk("disable_tx_valid", 128'(tx_valid0), 128'(0));
        enable = 1; tx_ready = 1; dac_valid = 1;
        for (int k = 0; k < 4; k++) begin rnd_data(); step(1); end
        dac_valid = 0;
        step(8);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            rnd_data();
            dac_valid = ($urandom % 10) < 7;
            tx_ready  = ($urandom % 10) < 8;
            en0       = ($urandom % 16) != 0;
            en1       = ($urandom % 16) != 0;
            enable    = ($urandom % 64) != 0;
            clr       = ($urandom % 32) == 0;
            rst       = ($urandom % 256) == 0;
            step(1);
        end
        rst = 0; clr = 0; dac_valid = 0;
        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
